// File: rtl/ram_fifo_ctrl.sv
// rtl/ram_fifo_ctrl.sv - FIFO controller around an external async-read RAM
// with a one-word registered output stage.
module ram_fifo_ctrl #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              in_valid_i,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              in_ready_o,
   output logic              out_valid_o,
   output logic [DATA_W-1:0] out_data_o,
   input  logic              out_ready_i,
   output logic              ram_we_o,
   output logic [ADDR_W-1:0] ram_waddr_o,
   output logic [ADDR_W-1:0] ram_raddr_o,
   output logic [DATA_W-1:0] ram_wdata_o,
   input  logic [DATA_W-1:0] ram_rdata_i,
   output logic [ADDR_W:0]   count_o,
   output logic              full_o,
   output logic              empty_o
);

   localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE_CNT  = (ADDR_W+1)'(1);

   typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;

   state_t            state;
   logic [ADDR_W-1:0] wptr;
   logic [ADDR_W-1:0] rptr;
   logic [ADDR_W:0]   count;
   logic              push;
   logic              pop;

   assign full_o      = (count == FULL_CNT);
   assign empty_o     = (count == '0);
   assign count_o     = count;
   assign in_ready_o  = !full_o;
   assign push        = in_valid_i && !full_o;
   // Gated by reset so no write can slip through while the block is held in reset.
   assign ram_we_o    = push && rst_n_i;
   assign ram_waddr_o = wptr;
   assign ram_wdata_o = in_data_i;
   assign ram_raddr_o = rptr;
   assign pop         = (state == VALID) && out_ready_i;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wptr        <= '0;
         rptr        <= '0;
         count       <= '0;
         state       <= IDLE;
         out_valid_o <= 1'b0;
         out_data_o  <= '0;
      end else begin
         if (push) wptr <= wptr + ADDR_W'(1);

         if (push && !pop)      count <= count + ONE_CNT;
         else if (!push && pop) count <= count - ONE_CNT;

         case (state)
            IDLE: begin
               if (count != '0) state <= FETCH;
            end
            FETCH: begin
               out_data_o  <= ram_rdata_i;
               out_valid_o <= 1'b1;
               state       <= VALID;
            end
            VALID: begin
               if (out_ready_i) begin
                  rptr        <= rptr + ADDR_W'(1);
                  out_valid_o <= 1'b0;
                  // count still includes the word leaving now
                  state       <= (count > ONE_CNT) ? FETCH : IDLE;
               end
            end
            default: begin
               state       <= IDLE;
               out_valid_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb/tb_ram_fifo_ctrl.sv - scoreboard bench for ram_fifo_ctrl with an async-read RAM model.
module tb_ram_fifo_ctrl;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ready;
   logic       ram_we;
   logic [3:0] ram_waddr;
   logic [3:0] ram_raddr;
   logic [7:0] ram_wdata;
   logic [7:0] ram_rdata;
   logic [4:0] count;
   logic       full;
   logic       empty;

   logic [7:0] mem [16];
   logic [7:0] exp_q [$];
   logic [3:0] wp;
   logic [3:0] rp;
   int         checks;
   int         errors;

   ram_fifo_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .in_valid_i  (in_valid),
      .in_data_i   (in_data),
      .in_ready_o  (in_ready),
      .out_valid_o (out_valid),
      .out_data_o  (out_data),
      .out_ready_i (out_ready),
      .ram_we_o    (ram_we),
      .ram_waddr_o (ram_waddr),
      .ram_raddr_o (ram_raddr),
      .ram_wdata_o (ram_wdata),
      .ram_rdata_i (ram_rdata),
      .count_o     (count),
      .full_o      (full),
      .empty_o     (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) if (ram_we) mem[ram_waddr] <= ram_wdata;
   assign ram_rdata = mem[ram_raddr];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Starts and ends at a falling edge; applies inputs for the coming rising edge.
   task automatic step(input logic v, input logic [7:0] d, input logic r,
                       output logic acc, output logic popped);
      logic [7:0] e;
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      #1;
      acc = v && (exp_q.size() < 16);
      chk("in_ready", 32'(in_ready), 32'(exp_q.size() < 16));
      chk("ram_we", 32'(ram_we), 32'(acc));
      chk("raddr", 32'(ram_raddr), 32'(rp));
      if (acc) begin
         chk("waddr", 32'(ram_waddr), 32'(wp));
         chk("wdata", 32'(ram_wdata), 32'(d));
         exp_q.push_back(d);
         wp = wp + 4'd1;
      end
      popped = out_valid && r;
      if (popped) begin
         if (exp_q.size() == 0) begin
            chk("pop_empty_model", 32'(out_data), 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("out_data", 32'(out_data), 32'(e));
         end
         rp = rp + 4'd1;
      end
      @(posedge clk);
      @(negedge clk);
      chk("count", 32'(count), 32'(exp_q.size()));
      chk("empty", 32'(empty), 32'(exp_q.size() == 0));
      chk("full", 32'(full), 32'(exp_q.size() == 16));
   endtask

   initial begin
      logic a;
      logic p;
      int   last;
      int   cyc;
      int   pushed;
      int   pops;
      checks    = 0;
      errors    = 0;
      wp        = '0;
      rp        = '0;
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h55;
      out_ready = 1'b1;

      // reset state, with a push attempted while in reset
      repeat (2) @(negedge clk);
      #1;
      chk("rst_count", 32'(count), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_ram_we", 32'(ram_we), 0);
      chk("rst_ptrs", 32'({ram_waddr, ram_raddr}), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // single word latency, first push right after reset release
      step(1'b1, 8'h6D, 1'b1, a, p);
      chk("lat_n0_valid", 32'(out_valid), 0);
      step(1'b0, 8'h00, 1'b1, a, p);
      chk("lat_n1_valid", 32'(out_valid), 0);
      step(1'b0, 8'h00, 1'b1, a, p);
      chk("lat_n2_valid", 32'(out_valid), 1);
      chk("lat_n2_data", 32'(out_data), 32'h6D);
      step(1'b0, 8'h00, 1'b1, a, p);
      chk("lat_popped", 32'(p), 1);
      chk("lat_empty_after", 32'(empty), 1);

      // fill to full, then a refused 17th push
      for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, a, p);
      chk("fill_full", 32'(full), 1);
      chk("fill_count", 32'(count), 16);
      chk("fill_in_ready", 32'(in_ready), 0);
      step(1'b1, 8'hAA, 1'b0, a, p);
      chk("push17_count", 32'(count), 16);

      // full with simultaneous push and pop: push refused
      step(1'b1, 8'hBB, 1'b1, a, p);
      chk("fullpop_popped", 32'(p), 1);
      chk("fullpop_count", 32'(count), 15);
      chk("fullpop_in_ready", 32'(in_ready), 1);

      // drain remainder, one word per two cycles
      last = -1;
      cyc  = 0;
      for (int k = 0; k < 100 && exp_q.size() > 0; k++) begin
         step(1'b0, 8'h00, 1'b1, a, p);
         cyc++;
         if (p) begin
            if (last >= 0) chk("drain_gap", 32'(cyc - last), 2);
            last = cyc;
         end
      end
      chk("drain_left", 32'(exp_q.size()), 0);
      chk("drain_empty", 32'(empty), 1);

      // continuous streaming, 40 words, pointers wrap
      pushed = 0;
      pops   = 0;
      for (int k = 0; k < 400 && (pushed < 40 || exp_q.size() > 0); k++) begin
         step(pushed < 40, 8'(pushed) + 8'h40, 1'b1, a, p);
         if (a) pushed++;
         if (p) pops++;
      end
      chk("stream_pushed", 32'(pushed), 40);
      chk("stream_pops", 32'(pops), 40);
      chk("stream_empty", 32'(empty), 1);

      // asynchronous reset while VALID with five words stored
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, a, p);
      step(1'b0, 8'h00, 1'b0, a, p);
      chk("pre_rst_valid", 32'(out_valid), 1);
      chk("pre_rst_count", 32'(count), 5);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(out_valid), 0);
      chk("arst_count", 32'(count), 0);
      chk("arst_empty", 32'(empty), 1);
      exp_q.delete();
      wp       = '0;
      rp       = '0;
      in_valid = 1'b1;
      @(negedge clk);
      #1;
      chk("arst_ram_we", 32'(ram_we), 0);
      chk("arst_in_ready", 32'(in_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 8'h33, 1'b1, a, p);
      chk("post_rst_accept", 32'(count), 1);
      for (int k = 0; k < 10 && exp_q.size() > 0; k++) step(1'b0, 8'h00, 1'b1, a, p);
      chk("post_rst_drained", 32'(exp_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 4, giving the RAM address width; depth is 2**ADDR_W words.
REQ-002 The block SHALL have parameter DATA_W, default 8, giving the RAM word width.
REQ-003 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid_i  input  1  upstream word available.
REQ-006 in_data_i  input  DATA_W  upstream word.
REQ-007 in_ready_o  output  1  block can accept a word this cycle.
REQ-008 out_valid_o  output  1  out_data_o holds a valid word.
REQ-009 out_data_o  output  DATA_W  downstream word.
REQ-010 out_ready_i  input  1  downstream accepts the word this cycle.
REQ-011 ram_we_o  output  1  RAM write enable, connected to the RAM write_ena_i.
REQ-012 ram_waddr_o  output  ADDR_W  RAM write address.
REQ-013 ram_raddr_o  output  ADDR_W  RAM read address.
REQ-014 ram_wdata_o  output  DATA_W  RAM write data, connected to the RAM bus_data_i.
REQ-015 ram_rdata_i  input  DATA_W  RAM read data, connected to the RAM bus_data_o.
REQ-016 count_o  output  ADDR_W+1  words stored, including any word held in the output stage.
REQ-017 full_o / empty_o  output  1 each  count_o == 2**ADDR_W / count_o == 0.

Function
REQ-018 Push: a word SHALL be accepted when in_valid_i && in_ready_o; in_ready_o = !full_o, combinational from registered state only.
REQ-019 ram_we_o SHALL be in_valid_i && !full_o; ram_waddr_o = wptr; ram_wdata_o = in_data_i; the RAM commits at that rising edge.
REQ-020 wptr SHALL increment modulo 2**ADDR_W on each accepted push.
REQ-021 ram_raddr_o SHALL equal rptr at all times; rptr SHALL increment modulo 2**ADDR_W on each pop.
REQ-022 Read FSM states SHALL be IDLE, FETCH and VALID.
REQ-023 IDLE: out_valid_o=0; go to FETCH when count_o>0 at the clock edge.
REQ-024 FETCH: hold ram_raddr_o for one cycle; at the next edge, latch ram_rdata_i into out_data_o and go to VALID.
REQ-025 VALID: out_valid_o=1, out_data_o stable. On out_ready_i the word is popped, and the FSM goes to FETCH if count_o>1, else to IDLE.
REQ-026 out_data_o SHALL change only on entry to VALID.
REQ-027 Latency: a word pushed into an empty block at edge N SHALL show out_valid_o=1 after edge N+2; sustained throughput is one word per 2 cycles.
REQ-028 count_o SHALL be +1 on push only, -1 on pop only, and unchanged on a simultaneous push and pop.
REQ-029 Push while full SHALL be refused (no RAM write, no pointer or count change), even if a pop occurs in the same cycle.
REQ-030 A read SHALL never target an address being written in the same cycle, because FETCH only addresses words already committed.
REQ-031 out_ready_i outside VALID SHALL have no effect.

Reset
REQ-032 While rst_n_i=0, the following SHALL hold: wptr=rptr=0, count_o=0, FSM=IDLE, out_valid_o=0, out_data_o=0, in_ready_o=1, empty_o=1, full_o=0, ram_we_o=0.
REQ-033 Reset mid-operation SHALL discard all stored words, including one in VALID, with no further RAM write after assertion; RAM contents are left untouched.
REQ-034 The first push SHALL be accepted at the first rising edge after rst_n_i deasserts.

Verification (ADDR_W=4, DATA_W=8)
REQ-035 Push 8'h6D at edge N with out_ready_i=1 -> ram_we_o=1 and ram_waddr_o=0 in cycle N; out_valid_o=1 with out_data_o=8'h6D after N+2; empty_o=1 after the pop.
REQ-036 Push 16 words 8'h00..8'h0F with out_ready_i=0 -> full_o=1, count_o=16, in_ready_o=0; a 17th push shows ram_we_o=0 and count_o stays 16.
REQ-037 Drain a full block with out_ready_i=1 -> words appear in order 8'h00..8'h0F, one per 2 cycles, ending with empty_o=1.
REQ-038 Run 40 words through with continuous push and pop -> pointers wrap past 15 to 0, and the output sequence equals the input sequence with no loss or duplication.
REQ-039 Full block, simultaneous push and pop -> push refused, count_o becomes 15, and next cycle in_ready_o=1.
REQ-040 Assert rst_n_i asynchronously mid-clock while in VALID with 5 words stored -> out_valid_o=0 and count_o=0 immediately, without waiting for a clock edge.
